dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the target side of the core's load/store port. It accepts one word-aligned read or write request at a time over a valid/ready request channel and services it against an internal word array after a programmable wait-state delay. It returns read data or a write acknowledge over a valid/ready response channel. It replaces the zero-latency combinational data memory when the pipelined core is exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, widths and the request error check for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Misaligned byte address or word index beyond the array.
    function automatic logic addr_error(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word array: synchronous write, asynchronous read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]              wdata,
    input  logic [BE_W-1:0]                be,
    output logic [WORD_W-1:0]              rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store target: one request at a time, serviced after LATENCY wait states.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        fsm_state
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e              state;
    logic [3:0]          cnt;
    logic                lat_we;
    logic [31:0]         lat_addr;
    logic [WORD_W-1:0]   lat_wdata;
    logic [BE_W-1:0]     lat_be;

    logic                commit;
    logic                c_we;
    logic [31:0]         c_addr;
    logic [WORD_W-1:0]   c_wdata;
    logic [BE_W-1:0]     c_be;
    logic                c_err;
    logic                arr_we;
    logic [WORD_W-1:0]   arr_rdata;

    // With zero latency the commit happens on the accepting edge, so the live request is used.
    always_comb begin
        commit  = 1'b0;
        c_we    = lat_we;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        c_be    = lat_be;
        if (state == ST_IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
            commit  = req_valid && (LATENCY == 0);
        end else if (state == ST_BUSY) begin
            commit  = (cnt == 4'd0);
        end
    end

    assign c_err  = addr_error(c_addr, 32'(DEPTH_WORDS));
    assign arr_we = rst && commit && c_we && !c_err;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (c_addr[AW+1:2]),
        .wdata (c_wdata),
        .be    (c_be),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        if (LATENCY == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (commit) begin
                rsp_err   <= c_err;
                rsp_rdata <= (c_we || c_err) ? '0 : arr_rdata;
            end
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign fsm_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench: three responders (LATENCY 2, 0, 4) exercised one at a time.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic [1:0]  fsm_state [3];

    logic [32:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          sel      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (1024),
            .LATENCY     (g == 0 ? 2 : (g == 1 ? 0 : 4))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .fsm_state (fsm_state[g])
        );
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every response handshake of the selected responder pops one entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid[sel] === 1'b1 && rsp_ready[sel] === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got err=%b rdata=%h, expected no response",
                         rsp_err[sel], rsp_rdata[sel]);
            end else begin
                check("rsp", {rsp_err[sel], rsp_rdata[sel]}, exp_q.pop_front());
            end
        end
    end

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic push, input logic [32:0] exp,
                             output int acc);
        req_we[sel]    = we;
        req_addr[sel]  = addr;
        req_wdata[sel] = wdata;
        req_be[sel]    = be;
        req_valid[sel] = 1'b1;
        if (push) exp_q.push_back(exp);
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[sel] === 1'b1) begin
                @(posedge clk);
                acc = cyc;
                break;
            end
            @(posedge clk);
        end
        #1 req_valid[sel] = 1'b0;
        if (acc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no acceptance, expected req_ready within 50 cycles");
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got no completion, expected finish before 200us");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int a1, a2, a3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_be[i]    = '0;
            rsp_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_req_ready", 33'(req_ready[i]), 33'd1);
            check("reset_rsp_valid", 33'(rsp_valid[i]), 33'd0);
            check("reset_rsp", {rsp_err[i], rsp_rdata[i]}, 33'd0);
            check("reset_state", 33'(fsm_state[i]), 33'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // LATENCY=2: write, acknowledge timing, read-back, byte enables, errors.
        sel = 0;
        drive_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, {1'b0, 32'h0}, a1);
        @(negedge clk); check("lat_edge_k1", 33'(rsp_valid[0]), 33'd0);
        @(negedge clk); check("lat_edge_k2", 33'(rsp_valid[0]), 33'd0);
        @(negedge clk); check("lat_edge_k3", 33'(rsp_valid[0]), 33'd1);
        wait_drain();
        drive_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, {1'b0, 32'hDEADBEEF}, a1);
        drive_req(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b1, {1'b0, 32'h0}, a1);
        drive_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, {1'b0, 32'hDE22BE44}, a1);
        drive_req(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b1, {1'b0, 32'h0}, a1);
        drive_req(1'b0, 32'h12, 32'h0, 4'hF, 1'b1, {1'b1, 32'h0}, a1);
        drive_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b1, {1'b1, 32'h0}, a1);
        drive_req(1'b1, 32'h0, 32'h12345678, 4'h0, 1'b1, {1'b0, 32'h0}, a1);
        drive_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, {1'b0, 32'h0BADF00D}, a1);
        wait_drain();

        // Backpressure: response held, new request ignored until the handshake.
        rsp_ready[0] = 1'b0;
        drive_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, {1'b0, 32'hDE22BE44}, a1);
        for (int i = 0; i < 20 && rsp_valid[0] !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h0;
        req_valid[0] = 1'b1;
        exp_q.push_back({1'b0, 32'h0BADF00D});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid", 33'(rsp_valid[0]), 33'd1);
            check("bp_rsp_data", {rsp_err[0], rsp_rdata[0]}, {1'b0, 32'hDE22BE44});
            check("bp_req_ready", 33'(req_ready[0]), 33'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 check("bp_idle_after_hs", 33'(req_ready[0]), 33'd1);
        @(posedge clk);
        #1 check("bp_next_accepted", 33'(req_ready[0]), 33'd0);
        req_valid[0] = 1'b0;
        wait_drain();

        // LATENCY=0: one accept every two cycles.
        sel = 1;
        drive_req(1'b1, 32'h8, 32'h55AA55AA, 4'hF, 1'b1, {1'b0, 32'h0}, a1);
        drive_req(1'b0, 32'h8, 32'h0, 4'hF, 1'b1, {1'b0, 32'h55AA55AA}, a1);
        check("l0_valid_after_accept", 33'(rsp_valid[1]), 33'd1);
        drive_req(1'b0, 32'h8, 32'h0, 4'hF, 1'b1, {1'b0, 32'h55AA55AA}, a2);
        drive_req(1'b0, 32'hFFC, 32'h0, 4'hF, 1'b1, {1'b0, 32'h0}, a3);
        check("l0_period_1", 33'(a2 - a1), 33'd2);
        check("l0_period_2", 33'(a3 - a2), 33'd2);
        wait_drain();
        drive_req(1'b0, 32'hFFD, 32'h0, 4'hF, 1'b1, {1'b1, 32'h0}, a1);
        wait_drain();

        // LATENCY=4: reset in BUSY drops the pending write.
        sel = 2;
        drive_req(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1, {1'b0, 32'h0}, a1);
        drive_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b1, {1'b0, 32'h12345678}, a1);
        wait_drain();
        drive_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 33'd0, a1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_busy_req_ready", 33'(req_ready[2]), 33'd1);
        check("rst_busy_rsp_valid", 33'(rsp_valid[2]), 33'd0);
        check("rst_busy_rsp", {rsp_err[2], rsp_rdata[2]}, 33'd0);
        check("rst_busy_state", 33'(fsm_state[2]), 33'd0);
        repeat (6) @(posedge clk);
        #1 check("rst_hold_no_rsp", 33'(rsp_valid[2]), 33'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b1, {1'b0, 32'h12345678}, a1);
        wait_drain();

        sel = 0;
        drive_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, {1'b0, 32'hDE22BE44}, a1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
